// File: rtl/led_blinker_multi_if.sv
// Configuration port of led_blinker_multi: one valid/ready word per channel update.
// LED_PWM_EN adds the per-word cfg_duty field.
interface led_blinker_multi_if #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 24
);
  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CHAN_W-1:0]    cfg_chan;
  logic [1:0]           cfg_mode;
  logic [CNT_WIDTH-1:0] cfg_half_period;
  logic [7:0]           cfg_count;
`ifdef LED_PWM_EN
  logic [7:0]           cfg_duty;
`endif

  modport master (
    output cfg_valid, cfg_chan, cfg_mode, cfg_half_period, cfg_count,
`ifdef LED_PWM_EN
    output cfg_duty,
`endif
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_mode, cfg_half_period, cfg_count,
`ifdef LED_PWM_EN
    input  cfg_duty,
`endif
    output cfg_ready
  );
endinterface

// File: rtl/led_blinker_multi.sv
// Multi-channel LED pattern driver (off / on / blink / counted burst) sharing one tick prescaler.
// Optional feature macro LED_PWM_EN: per-channel 8-bit duty gating of the on-phase.
module led_blinker_multi #(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_WIDTH = 24,
  parameter int unsigned PRESCALE  = 50
) (
  input  logic                 clock,
  input  logic                 reset_n,
  led_blinker_multi_if.slave   cfg,
  output logic [CHANNELS-1:0]  led_out,
  output logic [CHANNELS-1:0]  busy,
  output logic [CHANNELS-1:0]  burst_done
);
  localparam int unsigned CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  logic            ready_q;
  logic            xfer;
  logic [PS_W-1:0] presc_q;
  logic            tick;

  assign xfer          = cfg.cfg_valid & ready_q;
  assign cfg.cfg_ready = ready_q;
  assign tick          = (presc_q == PS_W'(PRESCALE - 1));

  // Ready is low out of reset and for the single cycle after each accepted word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ready_q <= 1'b0;
    else          ready_q <= ~xfer;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  presc_q <= '0;
    else if (tick) presc_q <= '0;
    else           presc_q <= presc_q + PS_W'(1);
  end

`ifdef LED_PWM_EN
  logic [7:0] pwm_q;
  logic [7:0] pwm_d;

  assign pwm_d = pwm_q + 8'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pwm_q <= 8'd0;
    else          pwm_q <= pwm_d;
  end
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    mode_e                mode_q, mode_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] last_q, last_d;
    logic [7:0]           cyc_q, cyc_d;
    logic [7:0]           tgt_q, tgt_d;
    logic                 phase_q, phase_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 sel;
`ifdef LED_PWM_EN
    logic [7:0]           duty_q, duty_d;
    logic                 led_q;
`endif

    // Out-of-range channel numbers never match, so such words are simply dropped.
    assign sel = xfer && (cfg.cfg_chan == CHAN_W'(g));

    always_comb begin
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      cyc_d   = cyc_q;
      tgt_d   = tgt_q;
      phase_d = phase_q;
      done_d  = 1'b0;
`ifdef LED_PWM_EN
      duty_d  = duty_q;
`endif
      if (sel) begin
        cnt_d  = '0;
        cyc_d  = 8'd0;
        tgt_d  = cfg.cfg_count;
        last_d = (cfg.cfg_half_period == '0) ? '0 : cfg.cfg_half_period - CNT_WIDTH'(1);
`ifdef LED_PWM_EN
        duty_d = cfg.cfg_duty;
`endif
        case (mode_e'(cfg.cfg_mode))
          MODE_OFF: begin
            mode_d  = MODE_OFF;
            phase_d = 1'b0;
          end
          MODE_ON: begin
            mode_d  = MODE_ON;
            phase_d = 1'b1;
          end
          MODE_BLINK: begin
            mode_d  = MODE_BLINK;
            phase_d = 1'b1;
          end
          MODE_BURST: begin
            // A zero-length burst completes immediately without lighting.
            if (cfg.cfg_count == 8'd0) begin
              mode_d  = MODE_OFF;
              phase_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              mode_d  = MODE_BURST;
              phase_d = 1'b1;
            end
          end
          default: mode_d = MODE_OFF;
        endcase
      end else if (tick && (mode_q == MODE_BLINK || mode_q == MODE_BURST)) begin
        if (cnt_q == last_q) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          if (mode_q == MODE_BURST && phase_q) begin
            cyc_d = cyc_q + 8'd1;
            if (cyc_d == tgt_q) begin
              mode_d  = MODE_OFF;
              phase_d = 1'b0;
              done_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      busy_d = (mode_d == MODE_BLINK) || (mode_d == MODE_BURST);
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        mode_q  <= MODE_OFF;
        cnt_q   <= '0;
        last_q  <= '0;
        cyc_q   <= 8'd0;
        tgt_q   <= 8'd0;
        phase_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        mode_q  <= mode_d;
        cnt_q   <= cnt_d;
        last_q  <= last_d;
        cyc_q   <= cyc_d;
        tgt_q   <= tgt_d;
        phase_q <= phase_d;
        busy_q  <= busy_d;
        done_q  <= done_d;
      end
    end

`ifdef LED_PWM_EN
    // Gate with the PWM count that will be current while this LED value is shown.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        duty_q <= 8'd0;
        led_q  <= 1'b0;
      end else begin
        duty_q <= duty_d;
        led_q  <= phase_d & (pwm_d < duty_d);
      end
    end
    assign led_out[g] = led_q;
`else
    assign led_out[g] = phase_q;
`endif
    assign busy[g]       = busy_q;
    assign burst_done[g] = done_q;
  end
endmodule

// File: tb/tb_led_blinker_multi.sv
// Scoreboard bench for led_blinker_multi (PRESCALE=2, CNT_WIDTH=8, CHANNELS=4, plus a 3-channel copy).
module tb_led_blinker_multi;
  localparam logic [1:0] M_OFF = 2'b00, M_ON = 2'b01, M_BLINK = 2'b10, M_BURST = 2'b11;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [3:0] led_out, busy, burst_done;
  logic [2:0] led3, busy3, done3;

  led_blinker_multi_if #(.CHANNELS(4), .CNT_WIDTH(8)) cfg ();
  led_blinker_multi_if #(.CHANNELS(3), .CNT_WIDTH(8)) cfg3 ();

  led_blinker_multi #(.CHANNELS(4), .CNT_WIDTH(8), .PRESCALE(2)) u_dut (
    .clock(clock), .reset_n(reset_n), .cfg(cfg),
    .led_out(led_out), .busy(busy), .burst_done(burst_done)
  );

  led_blinker_multi #(.CHANNELS(3), .CNT_WIDTH(8), .PRESCALE(2)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .cfg(cfg3),
    .led_out(led3), .busy(busy3), .burst_done(done3)
  );

  typedef struct packed {
    logic       ready;
    logic [3:0] led;
    logic [3:0] busy;
    logic [3:0] done;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Edges since reset release; the prescaler ticks on every even-numbered edge.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  function automatic exp_t observe();
    return {cfg.cfg_ready, led_out, busy, burst_done};
  endfunction

  // Issue one word so that it is accepted on a tick edge; acc returns that edge number.
  task automatic send(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] hp,
                      input logic [7:0] cnt, input logic [7:0] duty, output int acc);
    int tries = 0;
    @(negedge clock);
    if (cyc[0] == 1'b0) @(negedge clock);
    while (cfg.cfg_ready !== 1'b1 && tries < 4) begin
      repeat (2) @(negedge clock);
      tries++;
    end
    n_tests++;
    if (cfg.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready_timeout got %b want 1", cfg.cfg_ready);
    end
    cfg.cfg_valid       = 1'b1;
    cfg.cfg_chan        = ch;
    cfg.cfg_mode        = mode;
    cfg.cfg_half_period = hp;
    cfg.cfg_count       = cnt;
`ifdef LED_PWM_EN
    cfg.cfg_duty        = duty;
`else
    if (duty == 8'h5a) cfg.cfg_count = cnt;
`endif
    @(posedge clock);
    #1;
    acc = cyc;
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t o;
    exp_t e;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    o = observe();
    n_tests++;
    if (o !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL reset_hold got %h want %h", o, exp_t'(0));
    end
    reset_n = 1'b1;
    #1;
    o = observe();
    n_tests++;
    if (o !== exp_t'(0)) begin
      n_fail++;
      $display("FAIL reset_release got %h want %h", o, exp_t'(0));
    end
    for (int k = 0; k < 3; k++) sb_q.push_back('{1'b1, 4'h0, 4'h0, 4'h0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_ready k=%0d got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic test_blink();
    exp_t o, e;
    int a;
    send(2'd1, M_BLINK, 8'd3, 8'd0, 8'hff, a);
    for (int k = 0; k < 30; k++) begin
      e = '{k != 0, 4'h0, 4'b0010, 4'h0};
      e.led[1] = ((k / 6) % 2) == 0;
      sb_q.push_back(e);
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL blink k=%0d got %h want %h", k, o, e);
      end
    end
    send(2'd1, M_OFF, 8'd3, 8'd0, 8'hff, a);
    for (int k = 0; k < 4; k++) sb_q.push_back('{k != 0, 4'h0, 4'h0, 4'h0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL blink_off k=%0d got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic test_burst();
    exp_t o, e;
    int a;
    send(2'd2, M_BURST, 8'd1, 8'd3, 8'hff, a);
    for (int k = 0; k < 16; k++) begin
      e = '{k != 0, 4'h0, 4'h0, 4'h0};
      e.led[2]  = (k < 10) && (((k / 2) % 2) == 0);
      e.busy[2] = k < 10;
      e.done[2] = k == 10;
      sb_q.push_back(e);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL burst k=%0d got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic test_burst_zero();
    exp_t o, e;
    int a;
    send(2'd0, M_BURST, 8'd5, 8'd0, 8'hff, a);
    for (int k = 0; k < 6; k++) begin
      e = '{k != 0, 4'h0, 4'h0, 4'h0};
      e.done[0] = k == 0;
      sb_q.push_back(e);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL burst_zero k=%0d got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic test_invalid_chan();
    logic [9:0] o, e;
    @(negedge clock);
    cfg3.cfg_valid = 1'b1;
    cfg3.cfg_chan = 2'd3;
    cfg3.cfg_mode = M_BLINK;
    cfg3.cfg_half_period = 8'd1;
    @(posedge clock);
    #1;
    cfg3.cfg_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      e = {k != 0, 9'h000};
      o = {cfg3.cfg_ready, led3, busy3, done3};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL invalid_chan k=%0d got %h want %h", k, o, e);
      end
    end
    @(negedge clock);
    cfg3.cfg_valid = 1'b1;
    cfg3.cfg_chan = 2'd2;
    cfg3.cfg_mode = M_ON;
    @(posedge clock);
    #1;
    cfg3.cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      e = {k != 0, 3'b100, 3'b000, 3'b000};
      o = {cfg3.cfg_ready, led3, busy3, done3};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL valid_chan3 k=%0d got %h want %h", k, o, e);
      end
    end
  endtask

  task automatic test_abort();
    exp_t o, e;
    int a0, a1, a2;
    send(2'd1, M_BLINK, 8'd3, 8'd0, 8'hff, a0);
    send(2'd2, M_BURST, 8'd1, 8'd3, 8'hff, a1);
    for (int k = 0; k < 4; k++) begin
      e = '{k != 0, 4'h0, 4'b0110, 4'h0};
      e.led[2] = ((k / 2) % 2) == 0;
      e.led[1] = (((a1 + k - a0) / 6) % 2) == 0;
      sb_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort_pre k=%0d got %h want %h", k, o, e);
      end
    end
    send(2'd2, M_OFF, 8'd1, 8'd0, 8'hff, a2);
    for (int k = 0; k < 16; k++) begin
      e = '{k != 0, 4'h0, 4'b0010, 4'h0};
      e.led[1] = (((a2 + k - a0) / 6) % 2) == 0;
      sb_q.push_back(e);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort_post k=%0d got %h want %h", k, o, e);
      end
    end
    send(2'd1, M_OFF, 8'd1, 8'd0, 8'hff, a2);
  endtask

  task automatic test_half_zero_and_on();
    exp_t o, e;
    int a, a2;
    send(2'd0, M_BLINK, 8'd0, 8'd0, 8'hff, a);
    for (int k = 0; k < 8; k++) begin
      e = '{k != 0, 4'h0, 4'b0001, 4'h0};
      e.led[0] = ((k / 2) % 2) == 0;
      sb_q.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL half_zero k=%0d got %h want %h", k, o, e);
      end
    end
    send(2'd3, M_ON, 8'd4, 8'd0, 8'hff, a2);
    for (int k = 0; k < 6; k++) begin
      e = '{k != 0, 4'b1000, 4'b0001, 4'h0};
      e.led[0] = (((a2 + k - a) / 2) % 2) == 0;
      sb_q.push_back(e);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL on_mode k=%0d got %h want %h", k, o, e);
      end
    end
    send(2'd0, M_OFF, 8'd0, 8'd0, 8'hff, a);
    send(2'd3, M_OFF, 8'd0, 8'd0, 8'hff, a);
    for (int k = 0; k < 4; k++) sb_q.push_back('{k != 0, 4'h0, 4'h0, 4'h0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL all_off k=%0d got %h want %h", k, o, e);
      end
    end
  endtask

  // Valid held across two words: second waits out the ready gap, both bursts end together.
  task automatic test_back_to_back();
    exp_t o, e;
    @(negedge clock);
    if (cyc[0] == 1'b0) @(negedge clock);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_chan = 2'd0;
    cfg.cfg_mode = M_BURST;
    cfg.cfg_half_period = 8'd2;
    cfg.cfg_count = 8'd1;
    @(posedge clock);
    #1;
    cfg.cfg_chan = 2'd3;
    cfg.cfg_half_period = 8'd1;
    sb_q.push_back('{1'b0, 4'b0001, 4'b0001, 4'h0});
    sb_q.push_back('{1'b1, 4'b0001, 4'b0001, 4'h0});
    sb_q.push_back('{1'b0, 4'b1001, 4'b1001, 4'h0});
    sb_q.push_back('{1'b1, 4'b1001, 4'b1001, 4'h0});
    sb_q.push_back('{1'b1, 4'h0, 4'h0, 4'b1001});
    for (int k = 5; k < 10; k++) sb_q.push_back('{1'b1, 4'h0, 4'h0, 4'h0});
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k == 2) cfg.cfg_valid = 1'b0;
      e = sb_q.pop_front();
      o = observe();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back k=%0d got %h want %h", k, o, e);
      end
    end
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    int a;
    int highs;
    logic [7:0] duties [3];
    int want [3];
    duties[0] = 8'd64;  want[0] = 64;
    duties[1] = 8'd0;   want[1] = 0;
    duties[2] = 8'd255; want[2] = 255;
    for (int t = 0; t < 3; t++) begin
      send(2'd0, M_ON, 8'd1, 8'd0, duties[t], a);
      @(negedge clock);
      highs = 0;
      for (int k = 0; k < 256; k++) begin
        @(negedge clock);
        if (led_out[0] === 1'b1) highs++;
      end
      n_tests++;
      if (highs != want[t] || busy !== 4'h0) begin
        n_fail++;
        $display("FAIL pwm duty=%0d highs got %0d want %0d busy=%b", duties[t], highs, want[t], busy);
      end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cfg.cfg_valid = 1'b0;
    cfg.cfg_chan = '0;
    cfg.cfg_mode = M_OFF;
    cfg.cfg_half_period = '0;
    cfg.cfg_count = '0;
    cfg3.cfg_valid = 1'b0;
    cfg3.cfg_chan = '0;
    cfg3.cfg_mode = M_OFF;
    cfg3.cfg_half_period = '0;
    cfg3.cfg_count = '0;
`ifdef LED_PWM_EN
    cfg.cfg_duty = '0;
    cfg3.cfg_duty = '0;
`endif
    test_reset();
`ifdef LED_PWM_EN
    test_pwm();
`else
    test_blink();
    test_burst();
    test_burst_zero();
    test_invalid_chan();
    test_abort();
    test_half_zero_and_on();
    test_back_to_back();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
